// File: rtl/axicb_fifo_rdstage.sv
// axicb_fifo_rdstage: drains axicb_scfifo through pull/empty into a registered valid/ready stream
// using a two-entry skid buffer. Burst framing on m_last is built only when AXICB_RDSTAGE_LAST_EN is defined.
module axicb_fifo_rdstage #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  srst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pull,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            dbg_count
);

  // Handshake: a beat transfers in any cycle with m_valid & m_ready; once m_valid rises,
  // m_valid, m_data and m_last hold steady until that transfer. m_ready never feeds fifo_pull.
  typedef enum logic [1:0] {
    CNT_0 = 2'd0,
    CNT_1 = 2'd1,
    CNT_2 = 2'd2
  } count_t;

  count_t                count, count_nxt;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  clear, take, pop;
  logic                  load_main_fifo, load_main_skid, load_skid;

  assign clear     = srst | flush;
  assign fifo_pull = ~areset & ~clear & ~fifo_empty & (count != CNT_2);
  assign take      = fifo_pull;
  assign m_valid   = (count != CNT_0);
  assign pop       = m_valid & m_ready;
  assign m_data    = main_q;
  assign dbg_count = count;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) count <= CNT_0;
    else        count <= count_nxt;
  end

  always_comb begin
    count_nxt      = count;
    load_main_fifo = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (clear) begin
      count_nxt = CNT_0;
    end else begin
      case (count)
        CNT_0: begin
          if (take) begin
            load_main_fifo = 1'b1;
            count_nxt      = CNT_1;
          end
        end
        CNT_1: begin
          if (take && pop) begin
            load_main_fifo = 1'b1;
          end else if (take) begin
            load_skid = 1'b1;
            count_nxt = CNT_2;
          end else if (pop) begin
            count_nxt = CNT_0;
          end
        end
        CNT_2: begin
          // take cannot happen here: fifo_pull is masked while both entries are full
          if (pop) begin
            load_main_skid = 1'b1;
            count_nxt      = CNT_1;
          end
        end
        default: count_nxt = CNT_0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (load_main_fifo)      main_q <= fifo_data;
    else if (load_main_skid) main_q <= skid_q;
    if (load_skid)           skid_q <= fifo_data;
  end

`ifdef AXICB_RDSTAGE_LAST_EN
  logic [LEN_WIDTH-1:0] beat_cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)     beat_cnt <= '0;
    else if (clear) beat_cnt <= '0;
    else if (pop)   beat_cnt <= (beat_cnt == cfg_len) ? '0 : beat_cnt + LEN_WIDTH'(1);
  end

  assign m_last = m_valid & (beat_cnt == cfg_len);
`else
  logic unused_cfg_len;
  assign unused_cfg_len = ^cfg_len;
  assign m_last         = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_fifo_rdstage.sv
// Bench for axicb_fifo_rdstage: an external FIFO modelled as a queue, and a scoreboard queue of
// beats taken but not yet delivered; burst position is tracked as a plain beat index since the last clear.
module tb_axicb_fifo_rdstage;
  localparam int DW = 8;
  localparam int LW = 8;

`ifdef AXICB_RDSTAGE_LAST_EN
  localparam int EXP_LASTS = 2;
`else
  localparam int EXP_LASTS = 0;
`endif

  logic          aclk = 1'b0;
  logic          areset, srst, flush;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty, fifo_pull;
  logic [LW-1:0] cfg_len;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [1:0]    dbg_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            beat_n;
  int            feed_left;
  logic          exp_valid, exp_pull, exp_last;
  logic [DW-1:0] exp_data;
  int            exp_count;

  always #5 aclk = ~aclk;

  axicb_fifo_rdstage #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .srst      (srst),
    .flush     (flush),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_pull (fifo_pull),
    .cfg_len   (cfg_len),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .dbg_count (dbg_count)
  );

  task automatic set_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? DW'($urandom) : fifo_q[0];
  endtask

  // Reference: beats in flight = pulled minus delivered, capped at two; last = every (cfg_len+1)th beat.
  task automatic model_expect();
    exp_count = exp_q.size();
    exp_valid = (exp_count != 0);
    exp_data  = exp_valid ? exp_q[0] : '0;
    exp_pull  = !areset && !srst && !flush && (fifo_q.size() != 0) && (exp_count < 2);
`ifdef AXICB_RDSTAGE_LAST_EN
    exp_last  = exp_valid && ((beat_n % (int'(cfg_len) + 1)) == int'(cfg_len));
`else
    exp_last  = 1'b0;
`endif
  endtask

  task automatic tick();
    logic pull, pop;
    model_expect();
    pull = exp_pull;
    pop  = exp_valid && m_ready;
    @(posedge aclk);
    if (areset) begin
      exp_q.delete();
      beat_n = 0;
    end else if (srst || flush) begin
      exp_q.delete();
      beat_n = 0;
      if (flush) fifo_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        beat_n++;
      end
      if (pull) exp_q.push_back(fifo_q.pop_front());
    end
    #1;
    if (feed_left > 0 && $urandom_range(0, 3) != 0) begin
      fifo_q.push_back(DW'($urandom));
      feed_left--;
    end
    set_fifo();
  endtask

  task automatic test_reset();
    fifo_q = '{8'h33, 8'h44};
    m_ready = 1'b1;
    areset = 1'b1;
    set_fifo();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b0 || fifo_pull !== 1'b0 || m_last !== 1'b0 || dbg_count !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: valid=%b pull=%b last=%b count=%0d, required 0 0 0 0",
                 m_valid, fifo_pull, m_last, dbg_count);
      end
      tick();
    end
    fifo_q = '{8'h11};
    set_fifo();
    areset = 1'b0;
    #1;
    checks++;
    if (fifo_pull !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_pull: pull=%b valid=%b, required 1 0", fifo_pull, m_valid);
    end
    tick();
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      errors++;
      $display("FAIL reset_first_beat: valid=%b data=%h, required 1 11", m_valid, m_data);
    end
    tick();
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drained: valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_streaming();
    int            dut_beats = 0;
    logic [DW-1:0] want = 8'h01;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
    set_fifo();
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && dut_beats < 8; cyc++) begin
      #1;
      model_expect();
      checks++;
      if (dbg_count !== 2'(exp_count) || dbg_count > 2'd1) begin
        errors++;
        $display("FAIL stream_count: count=%0d, required %0d (max 1)", dbg_count, exp_count);
      end
      if (exp_valid) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== want) begin
          errors++;
          $display("FAIL stream_data: valid=%b data=%h, required 1 %h", m_valid, m_data, want);
        end
        want++;
      end
      if (m_valid === 1'b1) dut_beats++;
      tick();
    end
    checks++;
    if (dut_beats != 8) begin
      errors++;
      $display("FAIL stream_len: beats=%0d, required 8", dut_beats);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] want[4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    int k = 0;
    fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    set_fifo();
    for (int cyc = 0; cyc < 16 && k < 4; cyc++) begin
      m_ready = !(cyc >= 2 && cyc < 6);
      #1;
      model_expect();
      if (cyc >= 3 && cyc < 6) begin
        checks++;
        if (dbg_count !== 2'd2 || fifo_pull !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hA1) begin
          errors++;
          $display("FAIL bp_stall: count=%0d pull=%b valid=%b data=%h, required 2 0 1 a1",
                   dbg_count, fifo_pull, m_valid, m_data);
        end
      end else begin
        checks++;
        if (fifo_pull !== exp_pull) begin
          errors++;
          $display("FAIL bp_pull: cycle %0d pull=%b, required %b", cyc, fifo_pull, exp_pull);
        end
      end
      if (exp_valid && m_ready) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== want[k]) begin
          errors++;
          $display("FAIL bp_order: beat %0d valid=%b data=%h, required 1 %h", k, m_valid, m_data, want[k]);
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 4 || dbg_count !== 2'd0) begin
      errors++;
      $display("FAIL bp_done: beats=%0d count=%0d, required 4 0", k, dbg_count);
    end
  endtask

  task automatic test_flush();
    fifo_q = '{8'h55, 8'h66, 8'h77};
    m_ready = 1'b0;
    set_fifo();
    tick();
    tick();
    #1;
    checks++;
    if (dbg_count !== 2'd2 || m_data !== 8'h55) begin
      errors++;
      $display("FAIL flush_setup: count=%0d data=%h, required 2 55", dbg_count, m_data);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || dbg_count !== 2'd0) begin
      errors++;
      $display("FAIL flush_clear: valid=%b count=%0d, required 0 0", m_valid, dbg_count);
    end
    fifo_q = '{8'h5A};
    set_fifo();
    m_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
      errors++;
      $display("FAIL flush_next: valid=%b data=%h, required 1 5a", m_valid, m_data);
    end
    tick();
  endtask

  task automatic test_srst();
    fifo_q = '{8'h21, 8'h22};
    m_ready = 1'b0;
    set_fifo();
    tick();
    srst = 1'b1;
    #1;
    checks++;
    if (fifo_pull !== 1'b0 || dbg_count !== 2'd1) begin
      errors++;
      $display("FAIL srst_pull: pull=%b count=%0d, required 0 1", fifo_pull, dbg_count);
    end
    tick();
    srst = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || dbg_count !== 2'd0) begin
      errors++;
      $display("FAIL srst_clear: valid=%b count=%0d, required 0 0", m_valid, dbg_count);
    end
    m_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h22) begin
      errors++;
      $display("FAIL srst_next: valid=%b data=%h, required 1 22", m_valid, m_data);
    end
    tick();
  endtask

  task automatic test_framing();
    int            beats = 0;
    int            lasts = 0;
    int            cyc = 0;
    logic          stall = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    flush = 1'b1;
    cfg_len = 8'd3;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
    set_fifo();
    while (beats < 8 && cyc < 100) begin
      m_ready = ($urandom_range(0, 2) != 0);
      #1;
      model_expect();
      checks++;
      if (m_valid !== exp_valid || m_last !== exp_last || (exp_valid && m_data !== exp_data)) begin
        errors++;
        $display("FAIL frame_beat: valid=%b data=%h last=%b, required %b %h %b",
                 m_valid, m_data, m_last, exp_valid, exp_data, exp_last);
      end
      if (stall) begin
        checks++;
        if (m_data !== pd || m_last !== pl) begin
          errors++;
          $display("FAIL frame_stable: data=%h last=%b, required %h %b", m_data, m_last, pd, pl);
        end
      end
      stall = exp_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid === 1'b1 && m_ready) begin
        beats++;
        if (m_last === 1'b1) begin
          lasts++;
          checks++;
          if (beats % 4 != 0) begin
            errors++;
            $display("FAIL frame_last_pos: last on beat %0d, required beat 4 or 8", beats);
          end
        end
      end
      cyc++;
      tick();
    end
    checks++;
    if (beats != 8 || lasts != EXP_LASTS) begin
      errors++;
      $display("FAIL frame_count: beats=%0d lasts=%0d, required 8 %0d", beats, lasts, EXP_LASTS);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      flush = 1'b1;
      cfg_len = LW'($urandom_range(0, 5));
      tick();
      flush = 1'b0;
      feed_left = 40;
      for (int cyc = 0; cyc < 120; cyc++) begin
        m_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 60) == 0);
        #1;
        model_expect();
        checks++;
        if (fifo_pull !== exp_pull || m_valid !== exp_valid || m_last !== exp_last ||
            dbg_count !== 2'(exp_count) || (exp_valid && m_data !== exp_data)) begin
          errors++;
          $display("FAIL rand_cycle: r%0d c%0d pull=%b valid=%b data=%h last=%b count=%0d, required %b %b %h %b %0d",
                   round, cyc, fifo_pull, m_valid, m_data, m_last, dbg_count,
                   exp_pull, exp_valid, exp_data, exp_last, exp_count);
        end
        tick();
      end
      flush = 1'b0;
      feed_left = 0;
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && (exp_q.size() != 0 || fifo_q.size() != 0); cyc++) tick();
      #1;
      checks++;
      if (m_valid !== 1'b0 || fifo_pull !== 1'b0) begin
        errors++;
        $display("FAIL rand_drain: valid=%b pull=%b, required 0 0", m_valid, fifo_pull);
      end
    end
  endtask

  initial begin
    areset = 1'b1;
    srst = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    cfg_len = '0;
    beat_n = 0;
    feed_left = 0;
    fifo_q.delete();
    set_fifo();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_srst();
    test_framing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
